// File: rtl/btn_select_if.sv
// Button-select bundle: raw buttons in; debounced levels, selection code and press pulse out.
interface btn_select_if;
  logic [3:0] btn;
  logic [3:0] sel;
  logic       press;
  logic [3:0] stable;

  modport master (output btn, input sel, input press, input stable);
  modport slave  (input btn, output sel, output press, output stable);
endinterface

// File: rtl/btn_select.sv
// Four independent synchronize-and-debounce channels feeding a lowest-index-wins press selector.
module btn_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  btn_select_if.slave  io
);

  localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LAST_I = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];
  localparam bit ONE_CYCLE       = (DEBOUNCE_CYCLES == 1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    st_q  [4];
  logic [1:0]    st_d  [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    sel_q, sel_d;
  logic          press_q, press_d;
  logic [3:0]    rise;

  // The IDLE edge that sees the new level counts as the first of the
  // DEBOUNCE_CYCLES edges, so WAIT accepts once the counter reaches D-2.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      st_d[i]     = st_q[i];
      cnt_d[i]    = cnt_q[i];
      stable_d[i] = stable_q[i];
      case (st_q[i])
        IDLE_LOW: begin
          cnt_d[i] = '0;
          if (sync2_q[i]) begin
            if (ONE_CYCLE) begin
              stable_d[i] = 1'b1;
              st_d[i]     = IDLE_HIGH;
            end else begin
              st_d[i] = WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (!sync2_q[i]) begin
            st_d[i]  = IDLE_LOW;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            stable_d[i] = 1'b1;
            st_d[i]     = IDLE_HIGH;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        IDLE_HIGH: begin
          cnt_d[i] = '0;
          if (!sync2_q[i]) begin
            if (ONE_CYCLE) begin
              stable_d[i] = 1'b0;
              st_d[i]     = IDLE_LOW;
            end else begin
              st_d[i] = WAIT_LOW;
            end
          end
        end
        WAIT_LOW: begin
          if (sync2_q[i]) begin
            st_d[i]  = IDLE_HIGH;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == LAST) begin
            stable_d[i] = 1'b0;
            st_d[i]     = IDLE_LOW;
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_d[i]  = IDLE_LOW;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Selection is driven from stable_d so sel and press land on the same edge as stable.
  always_comb begin
    rise    = stable_d & ~stable_q;
    press_d = |rise;
    sel_d   = sel_q;
    casez (rise)
      4'b???1: sel_d = 4'b0001;
      4'b??10: sel_d = 4'b0010;
      4'b?100: sel_d = 4'b0100;
      4'b1000: sel_d = 4'b1000;
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      sel_q    <= '0;
      press_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]  <= IDLE_LOW;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= io.btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      sel_q    <= sel_d;
      press_q  <= press_d;
      for (int unsigned i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.sel    = sel_q;
  assign io.press  = press_q;
  assign io.stable = stable_q;

endmodule

// File: tb/tb_btn_select.sv
// Bench for btn_select with DEBOUNCE_CYCLES=5: expected presses are queued, a monitor pops them on each pulse.
module tb_btn_select;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  sel;
    logic [3:0]  stable;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int          n_vec;
  int          n_err;
  exp_t        exp_q[$];

  btn_select_if io ();

  btn_select #(.DEBOUNCE_CYCLES(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change issued now is expected to produce its pulse 7 edges later.
  task automatic expect_press(input logic [3:0] s, input logic [3:0] st);
    exp_t e;
    e.cyc    = cyc + 7;
    e.sel    = s;
    e.stable = st;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] es, input logic [3:0] est);
    n_vec++;
    if (io.sel !== es || io.stable !== est || io.press !== 1'b0) begin
      n_err++;
      $display("FAIL %s: sel=%b stable=%b press=%b, want sel=%b stable=%b press=0",
               name, io.sel, io.stable, io.press, es, est);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.press !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_press: cyc=%0d press=%b sel=%b, want no press",
                   cyc, io.press, io.sel);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (cyc != e.cyc) begin
            n_err++;
            $display("FAIL press_time: cyc=%0d, want %0d", cyc, e.cyc);
          end
          n_vec++;
          if (io.sel !== e.sel) begin
            n_err++;
            $display("FAIL press_sel: sel=%b, want %b", io.sel, e.sel);
          end
          n_vec++;
          if (io.stable !== e.stable) begin
            n_err++;
            $display("FAIL press_stable: stable=%b, want %b", io.stable, e.stable);
          end
        end
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    io.btn = 4'b0000;
    fork
      monitor();
    join_none

    tick(3);
    chk("reset_state", 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(2);

    // Clean press of btn[0], then release
    io.btn = 4'b0001;
    expect_press(4'b0001, 4'b0001);
    tick(6);
    chk("press0_edge6", 4'b0000, 4'b0000);
    tick(4);
    chk("press0_held", 4'b0001, 4'b0001);
    io.btn = 4'b0000;
    tick(6);
    chk("rel0_edge6", 4'b0001, 4'b0001);
    tick(1);
    chk("rel0_edge7", 4'b0001, 4'b0000);
    tick(5);

    // Bouncing btn[1] then steady
    io.btn = 4'b0010; tick(1);
    io.btn = 4'b0000; tick(1);
    io.btn = 4'b0010; tick(1);
    io.btn = 4'b0000; tick(1);
    io.btn = 4'b0010;
    expect_press(4'b0010, 4'b0010);
    tick(6);
    chk("bounce_edge6", 4'b0001, 4'b0000);
    tick(6);
    chk("bounce_held", 4'b0010, 4'b0010);
    io.btn = 4'b0000;
    tick(10);

    // Simultaneous rises resolve to lowest index
    io.btn = 4'b0110;
    expect_press(4'b0010, 4'b0110);
    tick(10);
    chk("simul_held", 4'b0010, 4'b0110);
    io.btn = 4'b0000;
    tick(10);
    chk("simul_rel", 4'b0010, 4'b0000);

    // btn[2], then btn[3] while btn[2] held, release and re-press btn[3]
    io.btn = 4'b0100;
    expect_press(4'b0100, 4'b0100);
    tick(10);
    io.btn = 4'b1100;
    expect_press(4'b1000, 4'b1100);
    tick(10);
    chk("b3_over_b2", 4'b1000, 4'b1100);
    io.btn = 4'b0100;
    tick(10);
    chk("b3_released", 4'b1000, 4'b0100);
    io.btn = 4'b1100;
    expect_press(4'b1000, 4'b1100);
    tick(10);
    io.btn = 4'b0000;
    tick(10);
    chk("all_released", 4'b1000, 4'b0000);

    // Reset in the middle of a pending rise; button still held afterwards
    io.btn = 4'b0001;
    tick(4);
    rst = 1'b1;
    #1;
    chk("rst_async", 4'b0000, 4'b0000);
    tick(2);
    rst = 1'b0;
    expect_press(4'b0001, 4'b0001);
    tick(6);
    chk("post_rst_edge6", 4'b0000, 4'b0000);
    tick(4);
    chk("post_rst_held", 4'b0001, 4'b0001);
    io.btn = 4'b0000;
    tick(10);

    // Four-cycle glitch on btn[3] is rejected
    io.btn = 4'b1000;
    tick(4);
    io.btn = 4'b0000;
    tick(12);
    chk("glitch3", 4'b0001, 4'b0000);

    tick(5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_press: %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_select.md
BTN_SELECT -- requirements
Module: btn_select

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive synchronized clock cycles a button level must hold before it is accepted; legal range 1..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port btn, input, 4 bits, raw asynchronous bouncing push-buttons, active-high.
REQ-005 The block SHALL have port sel, output, 4 bits, registered one-hot (or all-zero) code of the last accepted press; feeds the inp port of led_fsm.
REQ-006 The block SHALL have port press, output, 1 bit, one-cycle pulse marking each accepted press.
REQ-007 The block SHALL have port stable, output, 4 bits, registered debounced level of each button.

Function
REQ-008 Each btn[i] SHALL pass through a 2-flop synchronizer; its second-flop output is btn_s[i].
REQ-009 Each button SHALL have an independent debouncer with states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-010 IDLE_LOW -> WAIT_HIGH when btn_s[i]=1; IDLE_HIGH -> WAIT_LOW when btn_s[i]=0; counter cleared on entry.
REQ-011 In WAIT_x, counter SHALL increment each cycle the new level persists; any return to the old level SHALL go back to the IDLE state with counter cleared and stable[i] unchanged.
REQ-012 When btn_s[i] has differed from stable[i] for DEBOUNCE_CYCLES consecutive edges, stable[i] SHALL take the new level on that edge and the debouncer enters the matching IDLE state.
REQ-013 Latency from a clean raw btn change to stable change SHALL be exactly 2+DEBOUNCE_CYCLES rising edges.
REQ-014 On the edge where any stable[i] goes 0->1, sel SHALL load the one-hot code of i and press SHALL be 1 for exactly that following cycle.
REQ-015 Simultaneous accepted rises SHALL resolve to the lowest index (bit 0 highest priority); one press pulse only.
REQ-016 stable 1->0 transitions (releases) SHALL NOT change sel or pulse press.
REQ-017 Re-pressing the button already in sel SHALL pulse press with sel unchanged.
REQ-018 sel SHALL hold its value indefinitely between accepted presses; it is never all-ones or multi-hot.
REQ-019 With DEBOUNCE_CYCLES=1, a level held one synchronized cycle SHALL be accepted (WAIT state lasts one edge).
REQ-020 A button held high continuously SHALL produce exactly one press.

Reset
REQ-021 rst=1 SHALL immediately clear synchronizers, counters, stable=4'b0000, sel=4'b0000, press=0, all debouncers to IDLE_LOW, regardless of clock.
REQ-022 Buttons already held when rst deasserts SHALL be treated as new presses and accepted after 2+DEBOUNCE_CYCLES edges.
REQ-023 Reset asserted mid-WAIT SHALL abort the pending transition; no press is emitted for it.

Verification (DEBOUNCE_CYCLES=5)
REQ-024 Clean press btn=0001 held 10 cycles -> stable[0]=1, sel=0001, press one-cycle pulse exactly 7 edges after change; release -> stable[0]=0 after 7 edges, sel stays 0001, no pulse.
REQ-025 btn[1] bounce 1,0,1,0 per cycle then steady 1 -> no press during bounce; sel=0010 exactly 7 edges after last rise; single pulse.
REQ-026 btn=0110 asserted same cycle -> sel=0010, one press pulse, stable=0110.
REQ-027 Press btn[2] then btn[3] while btn[2] held -> sel 0100 then 1000, two pulses; re-press btn[3] -> pulse, sel=1000.
REQ-028 rst pulsed at edge 3 of a WAIT_HIGH on btn[0] -> outputs zero immediately, no pulse; btn[0] still high -> press 7 edges after rst release.
REQ-029 Glitch on btn[3] of 4 cycles high -> stable, sel, press unchanged.
